fm_retune_ctrl: RTL and testbench

FM_RETUNE_CTRL -- requirements
Module: fm_retune_ctrl

---
 rtl/fm_retune_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fm_retune_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_retune_ctrl.sv
// ---------------------------------------------------------------------------
// fm_retune_ctrl
//
// Purpose: retunes an FM modulator without glitches on the air. On an
// accepted request the DAC bit enables are ramped down MSB first, one bit
// per STEP_CYC cycles. The block then waits SETTLE_CYC silent cycles, loads
// the new carrier and deviation increments together, and ramps the enables
// back up LSB first toward the requested mask. The increments only ever
// change while every DAC bit is disabled.
//
// Ports:
//   clk          in   single clock for every register
//   rst          in   asynchronous, active-high reset
//   req_valid    in   retune request pending
//   req_ready    out  high only in IDLE; a request is taken on valid&&ready
//   req_acc_inc  in   [N-1:0] target carrier increment
//   req_df_inc   in   [L-1:0] target deviation increment
//   req_dac_ena  in   [D-1:0] target DAC bit enables
//   acc_inc      out  [N-1:0] carrier increment to fm_modulator
//   df_inc       out  [L-1:0] deviation increment to fm_modulator
//   dac_ena      out  [D-1:0] DAC bit enables
//   busy         out  retune sequence in progress (~req_ready)
//   done         out  one-cycle pulse on the edge that restores the last bit
// ---------------------------------------------------------------------------
module fm_retune_ctrl #(
  parameter int          N          = 18,
  parameter int          L          = 12,
  parameter int          D          = 4,
  parameter int          STEP_CYC   = 1024,
  parameter int          SETTLE_CYC = 256,
  parameter logic [N-1:0] RST_ACC   = 52429,
  parameter logic [L-1:0] RST_DF    = 393,
  parameter logic [D-1:0] RST_ENA   = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_acc_inc,
  input  logic [L-1:0] req_df_inc,
  input  logic [D-1:0] req_dac_ena,
  output logic [N-1:0] acc_inc,
  output logic [L-1:0] df_inc,
  output logic [D-1:0] dac_ena,
  output logic         busy,
  output logic         done
);

  // Step index counts the D enable bits; the down-counter covers the longer
  // of a step interval and the settle interval.
  localparam int IW   = (D > 1) ? $clog2(D) : 1;
  localparam int CMAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] STEP_LOAD   = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(D - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_DN = 2'd1,
    SETTLE  = 2'd2,
    RAMP_UP = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt,   w_cnt_nxt;
  logic [IW-1:0]  r_idx,   w_idx_nxt;
  logic [N-1:0]   r_tgt_acc, w_tgt_acc_nxt;
  logic [L-1:0]   r_tgt_df,  w_tgt_df_nxt;
  logic [D-1:0]   r_tgt_ena, w_tgt_ena_nxt;
  logic [N-1:0]   r_acc,   w_acc_nxt;
  logic [L-1:0]   r_df,    w_df_nxt;
  logic [D-1:0]   r_ena,   w_ena_nxt;
  logic           r_done,  w_done_nxt;

  logic           w_cnt_zero;
  logic [IW-1:0]  w_dn_bit;

  assign w_cnt_zero = (r_cnt == '0);
  // During the ramp-down, step r_idx has already cleared bit D-1-r_idx;
  // the next step clears the bit just below it.
  assign w_dn_bit   = IDX_LAST - r_idx - IW'(1);

  always_comb begin
    // NOTE: every next-state value takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_tgt_acc_nxt = r_tgt_acc;
    w_tgt_df_nxt  = r_tgt_df;
    w_tgt_ena_nxt = r_tgt_ena;
    w_acc_nxt     = r_acc;
    w_df_nxt      = r_df;
    w_ena_nxt     = r_ena;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_tgt_acc_nxt  = req_acc_inc;
          w_tgt_df_nxt   = req_df_inc;
          w_tgt_ena_nxt  = req_dac_ena;
          w_ena_nxt[D-1] = 1'b0;
          w_cnt_nxt      = STEP_LOAD;
          w_idx_nxt      = '0;
          w_state_nxt    = RAMP_DN;
        end
      end

      RAMP_DN: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_idx == IDX_LAST) begin
          // All bits have had their turn; force zero and go quiet.
          w_ena_nxt   = '0;
          w_cnt_nxt   = SETTLE_LOAD;
          w_idx_nxt   = '0;
          w_state_nxt = SETTLE;
        end else begin
          w_ena_nxt[w_dn_bit] = 1'b0;
          w_idx_nxt           = r_idx + IW'(1);
          w_cnt_nxt           = STEP_LOAD;
        end
      end

      SETTLE: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          // Both increments switch in the same cycle while the DAC is dark.
          w_acc_nxt   = r_tgt_acc;
          w_df_nxt    = r_tgt_df;
          w_cnt_nxt   = STEP_LOAD;
          w_idx_nxt   = '0;
          w_state_nxt = RAMP_UP;
        end
      end

      RAMP_UP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_ena_nxt[r_idx] = r_tgt_ena[r_idx];
          if (r_idx == IDX_LAST) begin
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
            w_cnt_nxt = STEP_LOAD;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tgt_acc <= '0;
      r_tgt_df  <= '0;
      r_tgt_ena <= '0;
      r_acc     <= RST_ACC;
      r_df      <= RST_DF;
      r_ena     <= RST_ENA;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_tgt_acc <= w_tgt_acc_nxt;
      r_tgt_df  <= w_tgt_df_nxt;
      r_tgt_ena <= w_tgt_ena_nxt;
      r_acc     <= w_acc_nxt;
      r_df      <= w_df_nxt;
      r_ena     <= w_ena_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = ~req_ready;
  assign acc_inc   = r_acc;
  assign df_inc    = r_df;
  assign dac_ena   = r_ena;
  assign done      = r_done;

endmodule

// File: tb/tb_fm_retune_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fm_retune_ctrl
//
// Purpose: self-checking bench for fm_retune_ctrl with D=4, STEP_CYC=4,
// SETTLE_CYC=8. A reference model tracks the cycle offset since each
// accepted request and derives the expected outputs from the retune
// timeline. Accepted targets go into a scoreboard queue that the monitor
// pops on every done pulse.
// ---------------------------------------------------------------------------
module tb_fm_retune_ctrl;

  localparam int N   = 18;
  localparam int L   = 12;
  localparam int D   = 4;
  localparam int S   = 4;
  localparam int Q   = 8;
  localparam int DS  = D * S;
  localparam int TOT = 2 * D * S + Q;

  localparam logic [N-1:0] RST_ACC = 18'd52429;
  localparam logic [L-1:0] RST_DF  = 12'd393;
  localparam logic [D-1:0] RST_ENA = 4'hF;

  typedef struct packed {
    logic [N-1:0] acc;
    logic [L-1:0] df;
    logic [D-1:0] ena;
  } tune_t;

  localparam tune_t RST_TUNE = '{acc: RST_ACC, df: RST_DF, ena: RST_ENA};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [N-1:0] req_acc_inc = '0;
  logic [L-1:0] req_df_inc = '0;
  logic [D-1:0] req_dac_ena = '0;
  logic         req_ready;
  logic [N-1:0] acc_inc;
  logic [L-1:0] df_inc;
  logic [D-1:0] dac_ena;
  logic         busy;
  logic         done;

  fm_retune_ctrl #(
    .N(N), .L(L), .D(D), .STEP_CYC(S), .SETTLE_CYC(Q),
    .RST_ACC(RST_ACC), .RST_DF(RST_DF), .RST_ENA(RST_ENA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_acc_inc(req_acc_inc),
    .req_df_inc (req_df_inc),
    .req_dac_ena(req_dac_ena),
    .acc_inc    (acc_inc),
    .df_inc     (df_inc),
    .dac_ena    (dac_ena),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  tune_t cur = RST_TUNE;  // expected DUT outputs after the latest edge
  tune_t old_v = RST_TUNE;
  tune_t tgt_v = RST_TUNE;
  bit    m_busy = 1'b0;
  int    m_t = 0;         // edges since accept (accept edge = 0)
  bit    e_done = 1'b0;
  int    n_accept = 0;
  tune_t sb_q[$];

  function automatic logic [D-1:0] low_mask(input int n);
    return D'((1 << n) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_t    = 0;
      e_done = 1'b0;
      cur    = RST_TUNE;
      sb_q.delete();
    end else begin
      e_done = 1'b0;
      if (m_busy) begin
        m_t++;
      end else if (req_valid) begin
        m_busy = 1'b1;
        m_t    = 0;
        old_v  = cur;
        tgt_v  = '{acc: req_acc_inc, df: req_df_inc, ena: req_dac_ena};
        sb_q.push_back(tgt_v);
        n_accept++;
      end
      if (m_busy) begin
        // Bits still lit during ramp-down: the low D-1-floor(t/S) of the old mask.
        if (m_t < DS)            cur.ena = old_v.ena & low_mask(D - 1 - m_t / S);
        else if (m_t < DS + Q + S) cur.ena = '0;
        else                     cur.ena = tgt_v.ena & low_mask((m_t - DS - Q) / S);
        if (m_t >= DS + Q) begin
          cur.acc = tgt_v.acc;
          cur.df  = tgt_v.df;
        end
        if (m_t == TOT) begin
          e_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] prev_acc = RST_ACC;
  logic [L-1:0] prev_df  = RST_DF;
  logic         prev_rst = 1'b1;

  always @(negedge clk) begin
    tune_t exp_t;
    check("req_ready", req_ready, !m_busy);
    check("busy",      busy,      m_busy);
    check("acc_inc",   acc_inc,   cur.acc);
    check("df_inc",    df_inc,    cur.df);
    check("dac_ena",   dac_ena,   cur.ena);
    check("done",      done,      e_done);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1, expected no pending request (t=%0t)", $time);
      end else begin
        exp_t = sb_q.pop_front();
        check("sb_acc", acc_inc, exp_t.acc);
        check("sb_df",  df_inc,  exp_t.df);
        check("sb_ena", dac_ena, exp_t.ena);
      end
    end
    if (!rst && !prev_rst && (acc_inc !== prev_acc || df_inc !== prev_df))
      check("inc_change_ena_zero", dac_ena, '0);
    prev_acc = acc_inc;
    prev_df  = df_inc;
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (n_accept != prev) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected one within 200 cycles (t=%0t)", $time);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy, expected idle within 200 cycles (t=%0t)", $time);
    end
  endtask

  task automatic issue(input tune_t v, input bit hold);
    int prev = n_accept;
    @(negedge clk);
    req_acc_inc = v.acc;
    req_df_inc  = v.df;
    req_dac_ena = v.ena;
    req_valid   = 1'b1;
    wait_accept(prev);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic scramble();
    req_acc_inc = N'($urandom);
    req_df_inc  = L'($urandom);
    req_dac_ena = D'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tune_t v;
    bit    ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic retune 1000/50/F.
    issue('{acc: 18'd1000, df: 12'd50, ena: 4'hF}, 1'b0);
    wait_idle();

    // Valid held across two requests; fields change after the first accept.
    issue('{acc: 18'd12345, df: 12'd77, ena: 4'hA}, 1'b1);
    issue('{acc: 18'd200000, df: 12'd4000, ena: 4'h6}, 1'b1);
    req_valid = 1'b0;
    scramble();
    wait_idle();

    // Partial enable mask, then scrambled inputs after accept.
    issue('{acc: 18'd777, df: 12'd9, ena: 4'h5}, 1'b0);
    scramble();
    wait_idle();

    // Zero enable mask, then a request identical to the current tuning.
    issue('{acc: 18'd3, df: 12'd1, ena: 4'h0}, 1'b0);
    wait_idle();
    issue(cur, 1'b0);
    wait_idle();

    // Reset in the settle phase at edge 20.
    issue('{acc: 18'd999, df: 12'd111, ena: 4'h3}, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (m_busy && m_t == 20) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_edge20", ok, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_acc",   acc_inc,   RST_ACC);
    check("rst_df",    df_inc,    RST_DF);
    check("rst_ena",   dac_ena,   RST_ENA);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy",  busy,      1'b0);
    check("rst_done",  done,      1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomised requests with idle gaps and occasional early re-assertion.
    for (int n = 0; n < 20; n++) begin
      v.acc = N'($urandom);
      v.df  = L'($urandom);
      v.ena = D'($urandom);
      issue(v, 1'b0);
      if ($urandom_range(0, 2) == 0) scramble();
      else wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
